fetch_unit: RTL

- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Owns PCF and handshakes with a variable-latency instruction memory.
- Consumes stallF, stallD and flushD from the hazard unit, and the PCSrcE redirect from EX.
- Produces PCD, PCPlus4D, instrD and validD for decode; inserts bubbles when memory has not yet returned an instruction.

---
 rtl/riscv_pipe_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types and constants for the 5-stage RISC-V core
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    function automatic logic isRedirect(input logic [1:0] pcSrc);
        return pcSrc != PCSRC_PLUS4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - flush/stall/load/bubble pipeline register for PC, PC+4, instruction, valid
module if_id_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] loadPC,
    input  logic [31:0]     loadInstr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [31:0]     instr,
    output logic            valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC      <= '0;
            PCPlus4 <= '0;
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end else if (flush) begin
            PC      <= '0;
            PCPlus4 <= '0;
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end else if (stall) begin
            PC      <= PC;
            PCPlus4 <= PCPlus4;
            instr   <= instr;
            valid   <= valid;
        end else if (load) begin
            PC      <= loadPC;
            PCPlus4 <= loadPC + XLEN'(4);
            instr   <= loadInstr;
            valid   <= 1'b1;
        end else begin
            // Bubble: PC fields keep their last value, only the payload is killed.
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage with variable-latency imem handshake; optional FETCH_PERF_CNT_EN perf counters
module fetch_unit
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [31:0]     imemRdata,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic [31:0]     instrD,
    output logic            validD,
    output logic [31:0]     perfBubbles,
    output logic [31:0]     perfRedirects
);

    fetch_state_t    state, stateNext;
    logic [XLEN-1:0] PCF, pcNext, PCPlus4F;
    logic [XLEN-1:0] redirPC, redirPCNext, target;
    logic [31:0]     holdInstr, holdInstrNext, availInstr;
    logic            redirect, available;

    assign redirect = isRedirect(PCSrcE);
    // Reserved encoding 11 falls through to the branch target.
    assign target   = (PCSrcE == PCSRC_JALR) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
    assign PCPlus4F = PCF + XLEN'(4);
    assign imemAddr = PCF;

    always_comb begin
        stateNext     = state;
        pcNext        = PCF;
        redirPCNext   = redirPC;
        holdInstrNext = holdInstr;
        imemReq       = 1'b1;
        available     = 1'b0;
        availInstr    = imemRdata;
        case (state)
            FETCH: begin
                if (imemAck) begin
                    if (redirect) begin
                        pcNext = target;
                    end else if (stallF) begin
                        holdInstrNext = imemRdata;
                        stateNext     = HOLD;
                    end else begin
                        available = 1'b1;
                        pcNext    = PCPlus4F;
                    end
                end else if (redirect) begin
                    redirPCNext = target;
                    stateNext   = DRAIN;
                end
            end
            DRAIN: begin
                // The in-flight request must retire before the new address is issued.
                if (redirect) begin
                    redirPCNext = target;
                end
                if (imemAck) begin
                    pcNext    = redirect ? target : redirPC;
                    stateNext = FETCH;
                end
            end
            HOLD: begin
                imemReq = 1'b0;
                if (redirect) begin
                    pcNext    = target;
                    stateNext = FETCH;
                end else if (!stallF) begin
                    available  = 1'b1;
                    availInstr = holdInstr;
                    pcNext     = PCPlus4F;
                    stateNext  = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            PCF       <= RESET_PC;
            redirPC   <= '0;
            holdInstr <= '0;
        end else begin
            state     <= stateNext;
            PCF       <= pcNext;
            redirPC   <= redirPCNext;
            holdInstr <= holdInstrNext;
        end
    end

    if_id_reg #(.XLEN(XLEN)) ifIdReg (
        .clk      (clk),
        .rst      (rst),
        .flush    (flushD),
        .stall    (stallD),
        .load     (available),
        .loadPC   (PCF),
        .loadInstr(availInstr),
        .PC       (PCD),
        .PCPlus4  (PCPlus4D),
        .instr    (instrD),
        .valid    (validD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubbleCnt, redirCnt;
    logic        bubbleLoad;

    assign bubbleLoad = !flushD && !stallD && !available;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubbleCnt <= '0;
            redirCnt  <= '0;
        end else begin
            if (bubbleLoad && (bubbleCnt != 32'hFFFF_FFFF)) begin
                bubbleCnt <= bubbleCnt + 32'd1;
            end
            if (redirect && (redirCnt != 32'hFFFF_FFFF)) begin
                redirCnt <= redirCnt + 32'd1;
            end
        end
    end

    assign perfBubbles   = bubbleCnt;
    assign perfRedirects = redirCnt;
`else
    assign perfBubbles   = '0;
    assign perfRedirects = '0;
`endif

endmodule
